// File: rtl/parity_frame_tx_pkg.sv
// Shared types and constants for the parity frame transmitter.
// Build option: define TX_ODD_PARITY_EN for odd parity (default even).
package parity_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Index width that stays legal for a single-bit payload.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parity_frame_tx_if.sv
// Upstream valid/ready word handshake into the frame transmitter.
interface parity_frame_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/parity_calc.sv
// Combinational parity reduction; odd parity when TX_ODD_PARITY_EN is defined,
// even parity otherwise. Shared with the receive-side checker.
module parity_calc #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_data,
    output logic         o_parity_c
);

`ifdef TX_ODD_PARITY_EN
    // Odd: data plus parity bit carries an odd number of ones.
    assign o_parity_c = ~^i_data;
`else
    // Even: data plus parity bit carries an even number of ones.
    assign o_parity_c = ^i_data;
`endif

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start(0), data LSB-first, parity, stop(1).
// Build option: TX_ODD_PARITY_EN selects odd parity (frame timing unchanged).
module parity_frame_tx
    import parity_frame_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    parity_frame_tx_if.slave         tx_if,
    output logic                     tx_out,
    output logic                     busy,
    output logic                     parity_bit
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = idx_width(DATA_W);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("parity_frame_tx: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("parity_frame_tx: DATA_W must be >= 1");
    end

    state_e              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [DATA_W-1:0]   r_shreg, w_shreg_nxt;
    logic                r_parity, w_parity_nxt;
    logic                r_tx_out, w_tx_out_nxt;
    logic                r_tx_ready, w_tx_ready_nxt;
    logic                r_busy, w_busy_nxt;
    logic                w_parity_c;
    logic                w_tc;

    parity_calc #(.W(DATA_W)) u_parity_calc (
        .i_data     (tx_if.tx_data),
        .o_parity_c (w_parity_c)
    );

    assign w_tc           = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign tx_out         = r_tx_out;
    assign busy           = r_busy;
    assign parity_bit     = r_parity;
    assign tx_if.tx_ready = r_tx_ready;

    // State and datapath registers; outputs registered from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shreg    <= '0;
            r_parity   <= 1'b0;
            r_tx_out   <= STOP_LEVEL;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_shreg    <= w_shreg_nxt;
            r_parity   <= w_parity_nxt;
            r_tx_out   <= w_tx_out_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state, bit timing, shifting and line level for the coming cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_shreg_nxt    = r_shreg;
        w_parity_nxt   = r_parity;
        w_tx_out_nxt   = STOP_LEVEL;
        w_tx_ready_nxt = 1'b0;
        w_busy_nxt     = 1'b1;

        if (r_state == ST_IDLE) begin
            if (tx_if.tx_valid && r_tx_ready) begin
                w_shreg_nxt  = tx_if.tx_data;
                w_parity_nxt = w_parity_c;
                w_cnt_nxt    = '0;
                w_state_nxt  = ST_START;
            end
        end else if (!w_tc) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_nxt = '0;
            unique case (r_state)
                ST_START: begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    w_shreg_nxt = r_shreg >> 1;
                    if (r_idx == IDX_W'(DATA_W - 1)) begin
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP:   w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end

        unique case (w_state_nxt)
            ST_START:  w_tx_out_nxt = START_LEVEL;
            ST_DATA:   w_tx_out_nxt = w_shreg_nxt[0];
            ST_PARITY: w_tx_out_nxt = w_parity_nxt;
            default:   w_tx_out_nxt = STOP_LEVEL;
        endcase

        w_tx_ready_nxt = (w_state_nxt == ST_IDLE);
        w_busy_nxt     = (w_state_nxt != ST_IDLE);
    end

endmodule
